fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V pipeline and the producer of everything decode consumes. It holds the program counter, issues in-order read requests to instruction memory over a valid/ready request channel, and buffers returned words in a small FIFO. It presents one instruction per cycle to decode as `instruction`, `pc_out` and prediction bits, holds them while decode stalls, and flushes on redirects from execute.

---
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RISC-V instruction fetch: PC, in-order imem requests, response
//            FIFO toward decode. Optional macro FETCH_STATIC_PREDICT_EN
//            enables static JAL/backward-branch prediction on pushed words.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int                  c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]    c_DEPTH    = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);

    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_exp_pc;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_outstanding;
    logic [c_CNT_W-1:0]  r_drop;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;

    logic [31:0]         r_word   [FIFO_DEPTH];
    logic [31:0]         r_pc     [FIFO_DEPTH];
    logic [31:0]         r_target [FIFO_DEPTH];
    logic                r_taken  [FIFO_DEPTH];

    logic [c_CNT_W:0]    w_occ_sum;
    logic                w_credit;
    logic                w_push;
    logic                w_pop;
    logic                w_req_fire;
    logic                w_self_redirect;
    logic                w_pred_taken;
    logic [31:0]         w_pred_target;
    logic [31:0]         w_redirect_pc;
    logic [c_CNT_W-1:0]  w_rsp_dec;
    logic [c_CNT_W-1:0]  w_out_next;
    logic [c_CNT_W-1:0]  w_count_next;

    // Credits cover both buffered and in-flight words, so a push never overflows.
    assign w_occ_sum     = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_credit      = (w_occ_sum < c_DEPTH);
    assign w_redirect_pc = redirect_pc & ~32'd3;
    assign w_rsp_dec     = imem_rsp_valid ? c_CNT_ONE : '0;

    assign w_push          = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_pop           = instr_valid && !stall && !redirect_valid;
    assign w_self_redirect = w_push && w_pred_taken;

    assign imem_req_valid = reset_n && !redirect_valid && !w_self_redirect && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

`ifdef FETCH_STATIC_PREDICT_EN
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;

    assign w_imm_j = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                      imem_rsp_data[30:21], 1'b0};
    assign w_imm_b = {{20{imem_rsp_data[31]}}, imem_rsp_data[7], imem_rsp_data[30:25],
                      imem_rsp_data[11:8], 1'b0};

    // Backward branches (negative offset) are assumed to be loop-closing and taken.
    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = r_exp_pc + 32'd4;
        if (imem_rsp_data[6:0] == c_OPC_JAL) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_exp_pc + w_imm_j;
        end else if ((imem_rsp_data[6:0] == c_OPC_BRANCH) && imem_rsp_data[31]) begin
            w_pred_taken  = 1'b1;
            w_pred_target = r_exp_pc + w_imm_b;
        end
    end
`else
    assign w_pred_taken  = 1'b0;
    assign w_pred_target = r_exp_pc + 32'd4;
`endif

    always_comb begin
        w_out_next = r_outstanding;
        if (w_req_fire && !imem_rsp_valid) begin
            w_out_next = r_outstanding + c_CNT_ONE;
        end else if (!w_req_fire && imem_rsp_valid) begin
            w_out_next = r_outstanding - c_CNT_ONE;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_exp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redirect_pc;
            r_exp_pc      <= w_redirect_pc;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= r_outstanding - w_rsp_dec;
            r_drop        <= r_outstanding - w_rsp_dec;
        end else begin
            r_outstanding <= w_out_next;
            r_count       <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_self_redirect) begin
                r_fetch_pc <= w_pred_target;
                r_exp_pc   <= w_pred_target;
                r_drop     <= r_outstanding - c_CNT_ONE;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_exp_pc <= r_exp_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word[r_wr_ptr]   <= imem_rsp_data;
            r_pc[r_wr_ptr]     <= r_exp_pc;
            r_taken[r_wr_ptr]  <= w_pred_taken;
            r_target[r_wr_ptr] <= w_pred_target;
        end
    end

    assign instr_valid = (r_count != '0);
    assign instruction = instr_valid ? r_word[r_rd_ptr]   : 32'd0;
    assign pc_out      = instr_valid ? r_pc[r_rd_ptr]     : 32'd0;
    assign pred_taken  = instr_valid ? r_taken[r_rd_ptr]  : 1'b0;
    assign pred_target = instr_valid ? r_target[r_rd_ptr] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with a fixed-latency
//            in-order instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam int          c_DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic [31:0] pred_target;

    int          n_pass = 0;
    int          n_total = 0;
    int          cycnum = 0;
    int          lat = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];

    fetch_stage #(
        .RESET_PC  (c_RESET_PC),
        .FIFO_DEPTH(c_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target)
    );

    always #5 clk = ~clk;

    // 0x40 holds beq x0,x0,-16; every other word is a non-control opcode.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hFE00_08E3;
        return {a[27:0], 4'h3};
    endfunction

    task automatic cyc();
        if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cycnum + lat);
        end
        @(posedge clk);
        cycnum++;
        @(negedge clk);
        redirect_valid = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cycnum) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        #1;
    endtask

    task automatic apply_reset(input int l);
        lat            = l;
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_req_ready = 1'b1;
        q_addr.delete();
        q_due.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycnum  = 0;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        q_addr.delete();
        q_due.delete();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %h want 0", imem_req_valid); else n_pass++;
        n_total++; if (imem_req_addr !== c_RESET_PC) $display("FAIL rst_req_addr got %h want %h", imem_req_addr, c_RESET_PC); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %h want 0", instr_valid); else n_pass++;
        n_total++; if (instruction !== 32'd0) $display("FAIL rst_instruction got %h want 0", instruction); else n_pass++;
        n_total++; if (pc_out !== 32'd0) $display("FAIL rst_pc_out got %h want 0", pc_out); else n_pass++;
        n_total++; if (pred_taken !== 1'b0) $display("FAIL rst_pred_taken got %h want 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'd0) $display("FAIL rst_pred_target got %h want 0", pred_target); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        cycnum  = 0;
        #1;
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got %h want 1", imem_req_valid); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        apply_reset(1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            n_total++;
            if (imem_req_addr !== c_RESET_PC + 32'(4 * i))
                $display("FAIL stream_req_addr[%0d] got %h want %h", i, imem_req_addr, c_RESET_PC + 32'(4 * i));
            else n_pass++;
            if (i >= 2) begin
                exp_pc = c_RESET_PC + 32'(4 * (i - 2));
                n_total++; if (instr_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %h want 1", i, instr_valid); else n_pass++;
                n_total++; if (pc_out !== exp_pc) $display("FAIL stream_pc[%0d] got %h want %h", i, pc_out, exp_pc); else n_pass++;
                n_total++; if (instruction !== mem_word(exp_pc)) $display("FAIL stream_instr[%0d] got %h want %h", i, instruction, mem_word(exp_pc)); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int          nreq;
        logic [31:0] exp_pc;
        apply_reset(1);
        stall = 1'b1;
        nreq  = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            if (imem_req_valid && imem_req_ready) nreq++;
            if (c >= 2) begin
                n_total++; if (pc_out !== c_RESET_PC) $display("FAIL stall_hold_pc[%0d] got %h want %h", c, pc_out, c_RESET_PC); else n_pass++;
            end
        end
        n_total++; if (nreq !== c_DEPTH) $display("FAIL stall_req_count got %0d want %0d", nreq, c_DEPTH); else n_pass++;
        for (int j = 0; j < 5; j++) begin
            cyc();
            stall = 1'b0;
            #1;
            exp_pc = c_RESET_PC + 32'(4 * j);
            n_total++; if (instr_valid !== 1'b1) $display("FAIL drain_valid[%0d] got %h want 1", j, instr_valid); else n_pass++;
            n_total++; if (pc_out !== exp_pc) $display("FAIL drain_pc[%0d] got %h want %h", j, pc_out, exp_pc); else n_pass++;
            n_total++; if (instruction !== mem_word(exp_pc)) $display("FAIL drain_instr[%0d] got %h want %h", j, instruction, mem_word(exp_pc)); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        apply_reset(4);
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        #1;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req_blocked got %h want 0", imem_req_valid); else n_pass++;
        cyc();
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL redir_req_valid got %h want 1", imem_req_valid); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h2000) $display("FAIL redir_req_addr got %h want 00002000", imem_req_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_valid_c4 got %h want 0", instr_valid); else n_pass++;
        for (int c = 5; c <= 8; c++) begin
            cyc();
            n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_drop_c%0d got %h want 0", c, instr_valid); else n_pass++;
        end
        cyc();
        n_total++; if (instr_valid !== 1'b1) $display("FAIL redir_first_valid got %h want 1", instr_valid); else n_pass++;
        n_total++; if (pc_out !== 32'h2000) $display("FAIL redir_first_pc got %h want 00002000", pc_out); else n_pass++;
        n_total++; if (instruction !== mem_word(32'h2000)) $display("FAIL redir_first_instr got %h want %h", instruction, mem_word(32'h2000)); else n_pass++;
    endtask

    task automatic test_redirect_same_cycle();
        apply_reset(1);
        cyc();
        cyc();
        n_total++; if (pc_out !== c_RESET_PC) $display("FAIL same_pre_pc got %h want %h", pc_out, c_RESET_PC); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL same_req_blocked got %h want 0", imem_req_valid); else n_pass++;
        cyc();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL same_valid_next got %h want 0", instr_valid); else n_pass++;
        n_total++; if (instruction !== 32'd0) $display("FAIL same_empty_instr got %h want 0", instruction); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h300) $display("FAIL same_req_addr got %h want 00000300", imem_req_addr); else n_pass++;
        n_total++; if (imem_req_valid !== 1'b1) $display("FAIL same_req_valid got %h want 1", imem_req_valid); else n_pass++;
        cyc();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL same_valid_c4 got %h want 0", instr_valid); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'h300) $display("FAIL same_new_pc got %h want 00000300", pc_out); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        cyc();
        n_total++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h want fffffffc", imem_req_addr); else n_pass++;
        cyc();
        n_total++; if (imem_req_addr !== 32'h0) $display("FAIL wrap_addr1 got %h want 00000000", imem_req_addr); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h want fffffffc", pc_out); else n_pass++;
        n_total++; if (pred_target !== 32'h0) $display("FAIL wrap_target got %h want 00000000", pred_target); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'h0) $display("FAIL wrap_pc1 got %h want 00000000", pc_out); else n_pass++;
        n_total++; if (instruction !== mem_word(32'h0)) $display("FAIL wrap_instr got %h want %h", instruction, mem_word(32'h0)); else n_pass++;
    endtask

    task automatic test_predict();
        apply_reset(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        cyc();
        cyc();
        cyc();
`ifdef FETCH_STATIC_PREDICT_EN
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL pred_req_blocked got %h want 0", imem_req_valid); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'h40) $display("FAIL pred_pc got %h want 00000040", pc_out); else n_pass++;
        n_total++; if (instruction !== 32'hFE00_08E3) $display("FAIL pred_instr got %h want fe0008e3", instruction); else n_pass++;
        n_total++; if (pred_taken !== 1'b1) $display("FAIL pred_taken got %h want 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h30) $display("FAIL pred_target got %h want 00000030", pred_target); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h30) $display("FAIL pred_req_addr got %h want 00000030", imem_req_addr); else n_pass++;
        cyc();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL pred_drop_valid got %h want 0", instr_valid); else n_pass++;
        cyc();
        cyc();
        n_total++; if (pc_out !== 32'h30) $display("FAIL pred_new_pc got %h want 00000030", pc_out); else n_pass++;
`else
        n_total++; if (imem_req_addr !== 32'h48) $display("FAIL nopred_req_addr got %h want 00000048", imem_req_addr); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'h40) $display("FAIL nopred_pc got %h want 00000040", pc_out); else n_pass++;
        n_total++; if (instruction !== 32'hFE00_08E3) $display("FAIL nopred_instr got %h want fe0008e3", instruction); else n_pass++;
        n_total++; if (pred_taken !== 1'b0) $display("FAIL nopred_taken got %h want 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h44) $display("FAIL nopred_target got %h want 00000044", pred_target); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h4C) $display("FAIL nopred_req_addr2 got %h want 0000004c", imem_req_addr); else n_pass++;
        cyc();
        n_total++; if (pc_out !== 32'h44) $display("FAIL nopred_next_pc got %h want 00000044", pc_out); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap();
        test_predict();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
